// File: rtl/dl_input_conditioner.sv
// Input conditioner for the digital lock: synchronizes buttons and digit switches, debounces
// each button, emits press/release pulses and captures the digit. Long-press via DL_COND_LONGPRESS_EN.
module dl_input_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned LONG_CYCLES     = 4000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic [3:0]         i_digit,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_release,
  output logic [3:0]         o_digit,
  output logic               o_digit_valid,
  output logic [NUM_BTN-1:0] o_long
);

  typedef enum logic [1:0] {ST_LOW, ST_ARM_H, ST_HIGH, ST_ARM_L} state_t;

  localparam int unsigned       DIG_W   = 4;
  localparam longint unsigned   CNT_LIM = (64'(1) << CNT_W) - 64'(1);
  localparam logic [CNT_W-1:0]  DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  // Reject counter widths too narrow for the requested durations.
  if (DEBOUNCE_CYCLES == 0 || 64'(DEBOUNCE_CYCLES) > CNT_LIM || 64'(LONG_CYCLES) > CNT_LIM) begin : g_bad_param
    $error("dl_input_conditioner: DEBOUNCE_CYCLES/LONG_CYCLES out of range for CNT_W");
  end

  logic [NUM_BTN-1:0] btn_s1, btn_s2;
  logic [DIG_W-1:0]   dig_s1, dig_s2;

  state_t             state_q [NUM_BTN];
  state_t             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] level_d, press_d, release_d;

  // Two-flop synchronizers for every raw input bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      btn_s1 <= i_btn;
      btn_s2 <= btn_s1;
      dig_s1 <= i_digit;
      dig_s2 <= dig_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-button debounce: any bounce while armed drops back and restarts the count.
  always_comb begin
    level_d   = o_level;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_LOW: begin
          if (btn_s2[i]) begin
            state_d[i] = ST_ARM_H;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_ARM_H: begin
          if (!btn_s2[i]) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_MAX) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!btn_s2[i]) begin
            state_d[i] = ST_ARM_L;
            cnt_d[i]   = CNT_ONE;
          end
        end
        ST_ARM_L: begin
          if (btn_s2[i]) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DEB_MAX) begin
            state_d[i]   = ST_LOW;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Registered outputs; digit loads on the same edge that raises o_digit_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level       <= '0;
      o_press       <= '0;
      o_release     <= '0;
      o_digit       <= '0;
      o_digit_valid <= 1'b0;
    end else begin
      o_level       <= level_d;
      o_press       <= press_d;
      o_release     <= release_d;
      o_digit_valid <= press_d[0];
      if (press_d[0]) begin
        o_digit <= dig_s2;
      end
    end
  end

`ifdef DL_COND_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0]   hold_q [NUM_BTN];
  logic [CNT_W-1:0]   hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_d;

  // Hold counter survives ARM_L glitches; cleared only on a fresh accepted press.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      hold_d[i] = hold_q[i];
      if (press_d[i]) begin
        hold_d[i] = '0;
      end else if ((state_q[i] == ST_HIGH || state_q[i] == ST_ARM_L) && hold_q[i] != LONG_MAX) begin
        hold_d[i] = hold_q[i] + CNT_ONE;
        long_d[i] = ((hold_q[i] + CNT_ONE) == LONG_MAX);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_long <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      o_long <= long_d;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end
`else
  assign o_long = '0;
`endif

endmodule

// File: tb/tb_dl_input_conditioner.sv
// Directed bench for dl_input_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Long-press expectations follow DL_COND_LONGPRESS_EN.
module tb_dl_input_conditioner;

  localparam int NB  = 4;
  localparam int LAT = 6;   // edges from E0 (first edge seeing the raw change) to the pulse
  localparam int LNG = 20;
`ifdef DL_COND_LONGPRESS_EN
  localparam int LONG_ON = 1;
`else
  localparam int LONG_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic [3:0]    digit;
  logic [NB-1:0] level, press, rel, lng;
  logic [3:0]    dig_out;
  logic          dig_vld;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int t0;
  int press_cnt [NB];
  int rel_cnt   [NB];
  int long_cnt  [NB];
  int press_at  [NB];
  int rel_at    [NB];
  int long_at   [NB];
  int dv_cnt;
  int long_total = 0;

  always #5 clk = ~clk;

  dl_input_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(LNG), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .i_digit(digit),
    .o_level(level), .o_press(press), .o_release(rel),
    .o_digit(dig_out), .o_digit_valid(dig_vld), .o_long(lng)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      press_at[i] = -1; rel_at[i] = -1; long_at[i] = -1;
    end
    dv_cnt = 0;
  endtask

  // Advance n edges, sampling 1ns after each edge and logging pulses.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NB; i++) begin
        if (press[i]) begin press_cnt[i]++; press_at[i] = cyc; end
        if (rel[i])   begin rel_cnt[i]++;   rel_at[i]   = cyc; end
        if (lng[i])   begin long_cnt[i]++;  long_at[i]  = cyc; long_total++; end
      end
      if (dig_vld) dv_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    digit = '0;
    clr_cnt();
    step(3);
    check("rst_level",   32'(level),   32'h0);
    check("rst_press",   32'(press),   32'h0);
    check("rst_release", 32'(rel),     32'h0);
    check("rst_digit",   32'(dig_out), 32'h0);
    check("rst_dvalid",  32'(dig_vld), 32'h0);
    check("rst_long",    32'(lng),     32'h0);
    rst_n = 1'b1;
    step(3);

    // Clean press on button 1, held 30 cycles
    clr_cnt();
    t0 = cyc;
    btn[1] = 1'b1;
    step(LAT);
    check("clean_no_early_press", 32'(press_cnt[1]), 32'd0);
    check("clean_level_pre",      32'(level[1]),     32'd0);
    step(1);
    check("clean_press",          32'(press[1]),     32'd1);
    check("clean_press_at",       32'(press_at[1]),  32'(t0 + 1 + LAT));
    check("clean_level",          32'(level[1]),     32'd1);
    step(1);
    check("clean_press_width",    32'(press[1]),     32'd0);
    step(22);
    check("clean_press_count",    32'(press_cnt[1]), 32'd1);
    check("clean_level_hold",     32'(level[1]),     32'd1);
    check("clean_long_count",     32'(long_cnt[1]),  32'(LONG_ON));
    if (LONG_ON != 0) check("clean_long_at", 32'(long_at[1]), 32'(t0 + 1 + LAT + LNG));
    t0 = cyc;
    btn[1] = 1'b0;
    step(LAT + 1);
    check("clean_release",        32'(rel[1]),       32'd1);
    check("clean_release_at",     32'(rel_at[1]),    32'(t0 + 1 + LAT));
    check("clean_level_low",      32'(level[1]),     32'd0);
    step(1);
    check("clean_release_width",  32'(rel[1]),       32'd0);
    check("clean_release_count",  32'(rel_cnt[1]),   32'd1);
    check("clean_other_press",    32'(press_cnt[0] + press_cnt[2] + press_cnt[3]), 32'd0);
    step(3);

    // Bounce on button 2: 1,0,1,0 every 2 cycles, then stays 1
    clr_cnt();
    for (int b = 0; b < 4; b++) begin
      btn[2] = (b % 2 == 0);
      step(2);
    end
    t0 = cyc;
    btn[2] = 1'b1;
    step(LAT);
    check("bounce_no_press",  32'(press_cnt[2]), 32'd0);
    step(1);
    check("bounce_press",     32'(press[2]),     32'd1);
    check("bounce_press_at",  32'(press_at[2]),  32'(t0 + 1 + LAT));
    btn[2] = 1'b0;
    step(10);
    check("bounce_press_cnt", 32'(press_cnt[2]), 32'd1);
    check("bounce_rel_cnt",   32'(rel_cnt[2]),   32'd1);

    // Digit capture on button 0
    clr_cnt();
    digit = 4'hB;
    step(3);
    btn[0] = 1'b1;
    step(LAT + 1);
    check("digit_valid",      32'(dig_vld),  32'd1);
    check("digit_value",      32'(dig_out),  32'hB);
    check("digit_press0",     32'(press[0]), 32'd1);
    digit = 4'hA;
    step(5);
    check("digit_hold",       32'(dig_out),  32'hB);
    btn[0] = 1'b0;
    step(10);
    check("digit_hold_rel",   32'(dig_out),  32'hB);
    check("digit_valid_cnt",  32'(dv_cnt),   32'd1);

    // Asynchronous reset while button 3 is arming, with o_digit = D
    digit = 4'hD;
    step(3);
    btn[0] = 1'b1;
    step(LAT + 2);
    check("rstmid_digit_pre", 32'(dig_out), 32'hD);
    btn[0] = 1'b0;
    step(10);
    clr_cnt();
    btn[3] = 1'b1;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_digit",     32'(dig_out), 32'h0);
    check("rstmid_level",     32'(level),   32'h0);
    check("rstmid_pulses",    32'({press, rel, lng}), 32'h0);
    check("rstmid_dvalid",    32'(dig_vld), 32'h0);
    step(3);
    rst_n = 1'b1;
    t0 = cyc;
    step(LAT + 2);
    check("rstmid_press_cnt", 32'(press_cnt[3]), 32'd1);
    check("rstmid_press_at",  32'(press_at[3]),  32'(t0 + 1 + LAT));
    btn[3] = 1'b0;
    step(10);

    // Simultaneous presses on buttons 0 and 1
    clr_cnt();
    btn = 4'b0011;
    step(LAT + 1);
    check("simul_press",      32'(press), 32'b0011);
    step(1);
    check("simul_press_end",  32'(press), 32'b0000);
    btn = 4'b0000;
    step(LAT + 1);
    check("simul_release",    32'(rel),   32'b0011);
    step(3);

    // Long press on button 3, held 40 cycles
    clr_cnt();
    t0 = cyc;
    btn[3] = 1'b1;
    step(40);
    check("long_press_at",    32'(press_at[3]), 32'(t0 + 1 + LAT));
    check("long_count",       32'(long_cnt[3]), 32'(LONG_ON));
    if (LONG_ON != 0) check("long_at", 32'(long_at[3]), 32'(t0 + 1 + LAT + LNG));
    btn[3] = 1'b0;
    step(12);
    check("long_count_after", 32'(long_cnt[3]), 32'(LONG_ON));
    check("long_release_cnt", 32'(rel_cnt[3]),  32'd1);
    check("long_total",       32'(long_total),  32'(2 * LONG_ON));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dl_input_conditioner.md
# dl_input_conditioner

Input-conditioning stage directly upstream of the digital-lock top level. It synchronizes the raw push buttons and the 4-bit digit switches, debounces each button independently, and produces clean levels plus single-cycle press and release pulses. It also captures the digit value on each press of the digit-confirm button. Its outputs drive the lock's confirm-getter, confirm-FSM, switch and hard-reset inputs and its digit input.

## Interface
- `NUM_BTN`, default 4: number of buttons. Index 0 = digit-confirm, 1 = FSM-confirm, 2 = mode switch, 3 = hard reset.
- `DEBOUNCE_CYCLES`, default 500: consecutive stable synchronized cycles required to accept a level change. Legal range 1 to 2^CNT_W−1.
- `LONG_CYCLES`, default 4000: hold duration that triggers a long-press pulse. Used only with `DL_COND_LONGPRESS_EN`.
- `CNT_W`, default 16: width of the per-button counters. Must satisfy 2^CNT_W−1 ≥ max(DEBOUNCE_CYCLES, LONG_CYCLES).
- `i_clk`  input  1  single system clock; all state changes on its rising edge.
- `i_rst_n`  input  1  asynchronous, active-low reset.
- `i_btn`  input  NUM_BTN  raw active-high buttons; asynchronous and bouncy.
- `i_digit`  input  4  raw digit switches; asynchronous.
- `o_level`  output  NUM_BTN  debounced button levels.
- `o_press`  output  NUM_BTN  one-cycle pulse on each accepted rising level.
- `o_release`  output  NUM_BTN  one-cycle pulse on each accepted falling level.
- `o_digit`  output  4  digit captured at the last press of button 0.
- `o_digit_valid`  output  1  one-cycle pulse, identical to `o_press[0]`.
- `o_long`  output  NUM_BTN  one-cycle long-press pulse; constant 0 when the feature is compiled out.

## Operation
- **Synchronizers.** Each `i_btn` bit and each `i_digit` bit passes through its own 2-flop synchronizer (`s1` → `s2`). All logic downstream uses the `s2` value only.
- **Per-button FSM.** Each button has an independent FSM with states LOW, ARM_H, HIGH and ARM_L, plus a counter `cnt`.
  - LOW: if `s2` = 1, go to ARM_H with `cnt` = 1.
  - ARM_H:
    - if `s2` = 0, return to LOW and clear `cnt`;
    - else if `cnt` = DEBOUNCE_CYCLES, go to HIGH, set `o_level` = 1, pulse `o_press`, clear `cnt`;
    - else increment `cnt`.
  - HIGH and ARM_L mirror LOW and ARM_H with polarity inverted. The ARM_L → LOW transition sets `o_level` = 0 and pulses `o_release`.
  - Any bounce during ARM restarts the count from scratch. There is no partial credit.
- **Buttons are independent.** Simultaneous presses on different buttons give simultaneous pulses on the corresponding bits.
- **Digit capture.**
  - On the edge that asserts `o_press[0]`, `o_digit` loads the synchronized digit value present at that edge.
  - `o_digit` holds its value otherwise.
  - Digit changes without a press of button 0 never reach `o_digit`.
- **Reset.**
  - Asynchronous assertion of `i_rst_n` = 0 forces the following to 0 / LOW immediately: all synchronizer flops, FSMs, counters, `o_level`, `o_press`, `o_release`, `o_digit`, `o_digit_valid` and `o_long`.
  - A reset mid-count discards the count.
  - A button held through reset release is treated as a new press: `o_press` fires after the normal debounce latency.
- **Saturation.** Counters never wrap. The ARM counter stops at DEBOUNCE_CYCLES and the long counter stops at LONG_CYCLES.

## Timing
- **Press latency.** Let raw `i_btn` rise before edge E0 and stay stable.
  - `s2` = 1 after edge E1.
  - ARM_H entered at E2.
  - `o_level` and `o_press` assert at edge E2 + DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES + 2 cycles. Release latency is identical.
- **Pulse widths.** `o_press`, `o_release`, `o_digit_valid` and `o_long` are each exactly 1 cycle wide and registered.
- **Same-edge updates.** `o_digit` updates on the same edge as `o_digit_valid` and is valid in that cycle.
- **DEBOUNCE_CYCLES = 1.** ARM lasts exactly one cycle; latency is 3 cycles.
- **Minimum gap.** Two accepted presses on one button are at least 2·(DEBOUNCE_CYCLES + 1) cycles apart.

## Configuration
- **`DL_COND_LONGPRESS_EN` defined.** Each button gets a hold counter.
  - The counter clears on entry to HIGH and increments each cycle in HIGH or ARM_L.
  - When it reaches LONG_CYCLES, `o_long` pulses once, one cycle, and the counter saturates.
  - No further `o_long` pulse until a new accepted press.
  - A glitch during ARM_L that returns to HIGH does not clear the hold counter.
- **`DL_COND_LONGPRESS_EN` not defined.** The hold counters are not built and `o_long` is tied to 0.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20, NUM_BTN = 4.
- **Clean press:** `i_btn[1]` 0→1, held 30 cycles, then 0 → `o_press[1]` 1 cycle at +6 cycles; `o_level[1]` high; `o_release[1]` 1 cycle 6 cycles after the fall.
- **Bounce:** `i_btn[2]` toggles 1,0,1,0 every 2 cycles, then stays 1 → no pulse during toggling; exactly one `o_press[2]` 6 cycles after the last rise.
- **Digit capture:** `i_digit` = 4'hB, press button 0 → `o_digit_valid` pulse with `o_digit` = 4'hB; change `i_digit` to 4'hA with no press → `o_digit` stays 4'hB.
- **Reset mid-operation:** `i_rst_n` = 0 asynchronously during ARM_H with `o_digit` = 4'hD → all outputs 0 immediately; button still held at release → `o_press` 6 cycles after reset deassertion.
- **Simultaneous:** `i_btn` = 4'b0011 on one edge → `o_press` = 4'b0011 on a single cycle.
- **Long press (macro on):** hold `i_btn[3]` 40 cycles → `o_press[3]` at +6, one `o_long[3]` at +26, no second pulse; with the macro off, `o_long` = 0 throughout.
